// File: rtl/vram_latency_model.sv
// Behavioural VRAM with byte writes, word reads and fixed read latency.
// Optional initial-busy access check is enabled by defining VRAM_MODEL_INIT_BUSY_EN.
module vram_latency_model #(
  parameter int ADDR_BITS  = 17,
  parameter int DATA_BYTES = 4,
  parameter int LATENCY    = 3,
  parameter int BLOCKING   = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    initial_busy,
  input  logic [ADDR_BITS-1:0]    vram_address,
  input  logic                    vram_valid,
  input  logic                    vram_write,
  input  logic [7:0]              vram_wdata,
  output logic                    vram_ready,
  output logic [8*DATA_BYTES-1:0] vram_rdata,
  output logic                    vram_rdata_en,
  output logic                    busy_violation
);

  localparam int LANE_BITS = $clog2(DATA_BYTES);
  localparam int WORD_BITS = ADDR_BITS - LANE_BITS;
  localparam int DATA_W    = 8 * DATA_BYTES;
  localparam int WORDS     = 1 << WORD_BITS;
  localparam logic [2:0] LANE_MASK = 3'(DATA_BYTES - 1);

  // Handshake: a command transfers on a rising edge where vram_valid and
  // vram_ready are both high; commands seen while reset is high never transfer.

  logic [DATA_W-1:0]    mem [WORDS];
  logic [WORD_BITS-1:0] word_idx;
  logic [2:0]           lane;
  logic                 take;
  logic                 take_ok;
  logic                 rd_go;
  logic                 wr_go;
  logic [LATENCY-1:0]   pipe_vld;
  logic [DATA_W-1:0]    pipe_data [LATENCY];

  always_comb begin
    word_idx = WORD_BITS'(vram_address >> LANE_BITS);
    lane     = 3'(vram_address) & LANE_MASK;
    take     = vram_valid && vram_ready && !reset;
`ifdef VRAM_MODEL_INIT_BUSY_EN
    take_ok  = take && !initial_busy;
`else
    take_ok  = take;
`endif
    rd_go    = take_ok && !vram_write;
    wr_go    = take_ok && vram_write;
  end

  // Memory is never reset; only the addressed lane changes on a write.
  always_ff @(posedge clk) begin
    if (wr_go) begin
      mem[word_idx][{lane, 3'b000} +: 8] <= vram_wdata;
    end
  end

  // Read data is captured at acceptance so later writes cannot leak into it.
  always_ff @(posedge clk) begin
    if (rd_go) begin
      pipe_data[0] <= mem[word_idx];
    end
    for (int i = 1; i < LATENCY; i++) begin
      pipe_data[i] <= pipe_data[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld[0] <= rd_go;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vram_rdata_en <= 1'b0;
      vram_rdata    <= '0;
    end else begin
      vram_rdata_en <= pipe_vld[LATENCY-1];
      if (pipe_vld[LATENCY-1]) begin
        vram_rdata <= pipe_data[LATENCY-1];
      end
    end
  end

  generate
    if (BLOCKING != 0) begin : g_blocking
      // Counts down the read latency; ready returns in the strobe cycle.
      logic [3:0] wait_cnt;

      always_ff @(posedge clk) begin
        if (reset) begin
          wait_cnt <= '0;
        end else if (rd_go) begin
          wait_cnt <= 4'(LATENCY);
        end else if (wait_cnt != 4'd0) begin
          wait_cnt <= wait_cnt - 4'd1;
        end
      end

      assign vram_ready = (wait_cnt == 4'd0);
    end else begin : g_pipelined
      assign vram_ready = 1'b1;
    end
  endgenerate

`ifdef VRAM_MODEL_INIT_BUSY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_violation <= 1'b0;
    end else if (take && initial_busy) begin
      busy_violation <= 1'b1;
    end
  end
`else
  logic unused_busy;
  assign unused_busy    = initial_busy;
  assign busy_violation = 1'b0;
`endif

endmodule

// File: tb/tb_vram_latency_model.sv
// Directed bench for vram_latency_model: default, pipelined (L=4) and 8-byte-wide instances.
// Expectations for the busy check follow VRAM_MODEL_INIT_BUSY_EN as defined for the build.
module tb_vram_latency_model;

  logic        clk;
  logic        reset;
  logic        initial_busy;
  logic [16:0] addr  [3];
  logic        valid [3];
  logic        write [3];
  logic [7:0]  wdata [3];
  logic        ready [3];
  logic        en    [3];
  logic        viol  [3];
  logic [31:0] rdata_def;
  logic [31:0] rdata_pipe;
  logic [63:0] rdata_wide;

  int cyc;
  int strb_cnt [3];
  int n_checks;
  int n_errors;

`ifdef VRAM_MODEL_INIT_BUSY_EN
  localparam logic        EXP_VIOL  = 1'b1;
  localparam logic [63:0] EXP_BUSYW = 64'h44332211;
`else
  localparam logic        EXP_VIOL  = 1'b0;
  localparam logic [63:0] EXP_BUSYW = 64'h44335511;
`endif

  vram_latency_model u_def (
    .clk(clk), .reset(reset), .initial_busy(initial_busy),
    .vram_address(addr[0]), .vram_valid(valid[0]), .vram_write(write[0]),
    .vram_wdata(wdata[0]), .vram_ready(ready[0]), .vram_rdata(rdata_def),
    .vram_rdata_en(en[0]), .busy_violation(viol[0])
  );

  vram_latency_model #(.LATENCY(4), .BLOCKING(0)) u_pipe (
    .clk(clk), .reset(reset), .initial_busy(initial_busy),
    .vram_address(addr[1]), .vram_valid(valid[1]), .vram_write(write[1]),
    .vram_wdata(wdata[1]), .vram_ready(ready[1]), .vram_rdata(rdata_pipe),
    .vram_rdata_en(en[1]), .busy_violation(viol[1])
  );

  vram_latency_model #(.ADDR_BITS(10), .DATA_BYTES(8)) u_wide (
    .clk(clk), .reset(reset), .initial_busy(initial_busy),
    .vram_address(addr[2][9:0]), .vram_valid(valid[2]), .vram_write(write[2]),
    .vram_wdata(wdata[2]), .vram_ready(ready[2]), .vram_rdata(rdata_wide),
    .vram_rdata_en(en[2]), .busy_violation(viol[2])
  );

  // Clock/reset and cycle bookkeeping
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int s = 0; s < 3; s++) begin
      strb_cnt[s] <= strb_cnt[s] + (en[s] ? 1 : 0);
    end
  end

  function automatic logic [63:0] rd(input int s);
    case (s)
      0:       rd = {32'h0, rdata_def};
      1:       rd = {32'h0, rdata_pipe};
      default: rd = rdata_wide;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver: called at a negedge, returns at the negedge after the acceptance edge.
  task automatic do_cmd(input int s, input logic wr, input logic [16:0] a,
                        input logic [7:0] d, output int acc);
    int n;
    valid[s] = 1'b1;
    write[s] = wr;
    addr[s]  = a;
    wdata[s] = d;
    n = 0;
    while (!ready[s] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", (n < 50), 1'b1);
    @(posedge clk);
    @(negedge clk);
    valid[s] = 1'b0;
    acc = cyc;
  endtask

  task automatic wait_strobe(input int s, input int acc, input int lat,
                             input logic [63:0] exp, input string tag);
    int n;
    n = 0;
    while (!en[s] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 64'(cyc - acc), 64'(lat));
    check({tag, "_data"}, rd(s), exp);
    @(negedge clk);
  endtask

  task automatic read_check(input int s, input logic [16:0] a, input int lat,
                            input logic [63:0] exp, input string tag);
    int acc;
    do_cmd(s, 1'b0, a, 8'h00, acc);
    wait_strobe(s, acc, lat, exp, tag);
  endtask

  logic [31:0] exp_w [3];

  initial begin
    int acc;
    int acc0;
    int base;
    n_checks = 0;
    n_errors = 0;
    initial_busy = 1'b0;
    for (int s = 0; s < 3; s++) begin
      valid[s] = 1'b0; write[s] = 1'b0; addr[s] = '0; wdata[s] = '0; strb_cnt[s] = 0;
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check("rst_ready", ready[0], 1'b1);
    check("rst_en", en[0], 1'b0);
    check("rst_rdata", rd(0), 64'h0);
    check("rst_viol", viol[0], 1'b0);
    check("rst_pipe_ready", ready[1], 1'b1);
    check("rst_wide_rdata", rd(2), 64'h0);

    // Default instance: byte writes then a word read with blocking ready
    for (int i = 0; i < 4; i++) begin
      do_cmd(0, 1'b1, 17'(i), 8'(8'h11 * (i + 1)), acc);
      check("wr_keeps_ready", ready[0], 1'b1);
    end
    base = strb_cnt[0];
    do_cmd(0, 1'b0, 17'd2, 8'h00, acc);
    for (int k = 0; k < 3; k++) begin
      check("blk_ready_low", ready[0], 1'b0);
      check("blk_no_strobe", en[0], 1'b0);
      @(negedge clk);
    end
    check("blk_lat", 64'(cyc - acc), 64'd3);
    check("blk_strobe", en[0], 1'b1);
    check("blk_ready_back", ready[0], 1'b1);
    check("blk_data", rd(0), 64'h44332211);
    @(negedge clk);
    check("blk_strobe_end", en[0], 1'b0);
    check("blk_hold", rd(0), 64'h44332211);
    check("blk_one_strobe", 64'(strb_cnt[0] - base), 64'd1);

    // Pipelined instance: three reads back to back
    for (int i = 0; i < 12; i++) begin
      do_cmd(1, 1'b1, 17'(i), 8'(8'h10 + i), acc);
    end
    exp_w[0] = 32'h13121110;
    exp_w[1] = 32'h17161514;
    exp_w[2] = 32'h1B1A1918;
    do_cmd(1, 1'b0, 17'd0, 8'h00, acc0);
    check("pipe_ready0", ready[1], 1'b1);
    do_cmd(1, 1'b0, 17'd4, 8'h00, acc);
    check("pipe_ready1", ready[1], 1'b1);
    do_cmd(1, 1'b0, 17'd8, 8'h00, acc);
    while (cyc <= acc0 + 7) begin
      check("pipe_ready", ready[1], 1'b1);
      if (cyc >= acc0 + 4 && cyc <= acc0 + 6) begin
        check("pipe_strobe", en[1], 1'b1);
        check("pipe_data", rd(1), {32'h0, exp_w[cyc - acc0 - 4]});
      end else begin
        check("pipe_idle", en[1], 1'b0);
      end
      @(negedge clk);
    end

    // Read snapshot survives a write accepted on the next cycle
    do_cmd(1, 1'b0, 17'd0, 8'h00, acc0);
    do_cmd(1, 1'b1, 17'd0, 8'hAA, acc);
    wait_strobe(1, acc0, 4, 64'h13121110, "snap_old");
    read_check(1, 17'd0, 4, 64'h131211AA, "snap_new");

    // Reset one cycle after acceptance flushes the read
    do_cmd(0, 1'b0, 17'd0, 8'h00, acc);
    base = strb_cnt[0];
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("flush_en", en[0], 1'b0);
    check("flush_rdata", rd(0), 64'h0);
    check("flush_ready", ready[0], 1'b1);
    repeat (6) @(negedge clk);
    check("flush_no_strobe", 64'(strb_cnt[0] - base), 64'd0);
    check("flush_ready_held", ready[0], 1'b1);
    // Command during reset must be dropped
    reset = 1'b1;
    valid[0] = 1'b1; write[0] = 1'b1; addr[0] = 17'd3; wdata[0] = 8'h99;
    @(negedge clk);
    reset = 1'b0;
    valid[0] = 1'b0;
    read_check(0, 17'd0, 3, 64'h44332211, "mem_kept");

    // Access while initial_busy
    initial_busy = 1'b1;
    do_cmd(0, 1'b1, 17'd1, 8'h55, acc);
    repeat (2) @(negedge clk);
    check("busy_viol", viol[0], EXP_VIOL);
    initial_busy = 1'b0;
    read_check(0, 17'd0, 3, EXP_BUSYW, "busy_data");
    check("busy_viol_sticky", viol[0], EXP_VIOL);

    // Wide instance: top byte of last word, no wrap into word 0
    for (int i = 0; i < 8; i++) begin
      do_cmd(2, 1'b1, 17'(10'h3F8 + i), 8'(8'hA0 + i), acc);
      do_cmd(2, 1'b1, 17'(i), 8'(8'h50 + i), acc);
    end
    do_cmd(2, 1'b1, 17'h3FF, 8'hC7, acc);
    read_check(2, 17'h3F8, 3, 64'hC7A6A5A4A3A2A1A0, "wide_top");
    read_check(2, 17'h000, 3, 64'h5756555453525150, "wide_nowrap");

    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("viol_cleared", viol[0], 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vram_latency_model.md
VRAM_LATENCY_MODEL -- requirements
Module: vram_latency_model

Interface
REQ-001 The module SHALL have the parameter ADDR_BITS, default 17, giving the byte address width; memory size is 2^ADDR_BITS bytes.
REQ-002 The module SHALL have the parameter DATA_BYTES, default 4, giving the read word width in bytes; legal values are 1, 2, 4 and 8.
REQ-003 The module SHALL have the parameter LATENCY, default 3, giving the cycles from read acceptance to data; legal range is 1..8.
REQ-004 The module SHALL have the parameter BLOCKING, default 1; 1 means a single outstanding read, 0 means fully pipelined reads.
REQ-005 The module SHALL have the port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-006 The module SHALL have the port reset, input, width 1: synchronous, active-high reset.
REQ-007 The module SHALL have the port initial_busy, input, width 1: the host-side "VRAM not yet usable" indication.
REQ-008 The module SHALL have the port vram_address, input, width ADDR_BITS: the byte address.
REQ-009 The module SHALL have the port vram_valid, input, width 1: command request.
REQ-010 The module SHALL have the port vram_write, input, width 1: 1 means write, 0 means read.
REQ-011 The module SHALL have the port vram_wdata, input, width 8: the write byte.
REQ-012 The module SHALL have the port vram_ready, output, width 1: command accepted when both vram_valid and vram_ready are high.
REQ-013 The module SHALL have the port vram_rdata, output, width 8*DATA_BYTES: the read word.
REQ-014 The module SHALL have the port vram_rdata_en, output, width 1: a one-cycle strobe marking vram_rdata valid.
REQ-015 The module SHALL have the port busy_violation, output, width 1: a sticky flag for an access made during initial_busy.

Function
REQ-016 The module SHALL accept at most one command per cycle, at a rising edge where vram_valid and vram_ready are both high.
REQ-017 The module SHALL store an accepted write's vram_wdata into byte lane vram_address[log2(DATA_BYTES)-1:0] of word vram_address[ADDR_BITS-1:log2(DATA_BYTES)], leaving the other lanes unchanged.
REQ-018 An accepted read SHALL ignore the lane bits and snapshot the whole word at its acceptance edge, so writes accepted later do not alter the returned data.
REQ-019 For a read accepted at edge N, vram_rdata_en SHALL be high for exactly the one cycle following edge N+LATENCY, with vram_rdata valid in that cycle.
REQ-020 vram_rdata SHALL hold its last returned value until the next strobe.
REQ-021 With BLOCKING=1, vram_ready SHALL go low for the LATENCY cycles following the read acceptance edge and return high in the strobe cycle, so back-to-back reads are spaced LATENCY+1 cycles apart.
REQ-022 With BLOCKING=1, a write SHALL never deassert vram_ready.
REQ-023 With BLOCKING=0, vram_ready SHALL be held at 1; up to LATENCY reads may be in flight and SHALL return strictly in acceptance order, one strobe per read.
REQ-024 With BLOCKING=0, a write accepted between overlapping reads SHALL be applied without disturbing the in-flight reads.
REQ-025 Memory contents SHALL be undefined until written.

Reset
REQ-026 While reset is high at a rising edge, the module SHALL set vram_rdata_en=0, vram_rdata=0, vram_ready=1 and busy_violation=0.
REQ-027 Reset SHALL flush all in-flight reads, so that no strobe is issued for them after reset releases.
REQ-028 Reset SHALL NOT clear memory contents.
REQ-029 Commands presented while reset is high SHALL be ignored.

Configuration
REQ-030 The macro VRAM_MODEL_INIT_BUSY_EN SHALL control the initial-busy check.
REQ-031 When VRAM_MODEL_INIT_BUSY_EN is defined, a command accepted while initial_busy is high SHALL be discarded (no memory write, no strobe), and busy_violation SHALL be set on the following edge and stay set until reset.
REQ-032 When VRAM_MODEL_INIT_BUSY_EN is undefined, initial_busy SHALL be ignored and busy_violation SHALL be tied to 0.

Verification
REQ-033 Defaults: write 0x11, 0x22, 0x33 and 0x44 to addresses 0..3, then read address 2 -> a single strobe 3 cycles after acceptance with vram_rdata=0x44332211, and vram_ready low for 3 cycles.
REQ-034 BLOCKING=0, LATENCY=4: reads of words 0, 1 and 2 on consecutive cycles -> three strobes on consecutive cycles with data in order and vram_ready always 1.
REQ-035 Read word 0 then write 0xAA to address 0 on the next cycle (BLOCKING=0) -> the read returns the old value; a later read returns 0x..AA.
REQ-036 Assert reset 1 cycle after read acceptance -> no strobe, vram_rdata=0, vram_ready=1; memory keeps the earlier data.
REQ-037 With VRAM_MODEL_INIT_BUSY_EN defined and initial_busy=1, write 0x55 -> busy_violation=1 and the subsequent read after busy drops returns the unchanged value; without the macro the write lands and busy_violation=0.
REQ-038 DATA_BYTES=8, ADDR_BITS=10: write address 0x3FF, then read 0x3F8 -> byte 7 updated, no address wrap into word 0.
